// File: rtl/product_accumulator.sv
// Accumulates groups of N_TERMS signed products into one overflow-free sum and
// presents each group sum with its term count on a valid/ready output.
module product_accumulator #(
  parameter int PROD_W  = 64,
  parameter int N_TERMS = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic signed [PROD_W-1:0]              in_data,
  input  logic                                  flush,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [PROD_W+$clog2(N_TERMS)-1:0] out_sum,
  output logic [$clog2(N_TERMS+1)-1:0]          out_count
);

  localparam int CNT_W = $clog2(N_TERMS+1);
  localparam int ACC_W = PROD_W + $clog2(N_TERMS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {INIT, ACCUM, SEND} state_t;

  function automatic logic signed [ACC_W-1:0] sign_ext(input logic signed [PROD_W-1:0] d);
    return {{(ACC_W-PROD_W){d[PROD_W-1]}}, d};
  endfunction

  state_t                   state, state_nxt;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic signed [ACC_W-1:0]  out_sum_nxt;
  logic [CNT_W-1:0]         out_count_nxt;
  logic                     out_valid_nxt;
  logic                     in_ready_nxt;
  logic                     xfer;
  logic signed [ACC_W-1:0]  sum_in;

  assign xfer   = in_valid && in_ready && (state == ACCUM);
  assign sum_in = acc + sign_ext(in_data);

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    out_sum_nxt   = out_sum;
    out_count_nxt = out_count;
    out_valid_nxt = out_valid;
    in_ready_nxt  = in_ready;
    case (state)
      INIT: begin
        in_ready_nxt = 1'b1;
        state_nxt    = ACCUM;
      end
      ACCUM: begin
        if (xfer) begin
          if ((cnt == LAST_CNT) || flush) begin
            // Closing transfer: the accepted term is folded into the emitted sum.
            out_sum_nxt   = sum_in;
            out_count_nxt = cnt + CNT_ONE;
            out_valid_nxt = 1'b1;
            in_ready_nxt  = 1'b0;
            acc_nxt       = '0;
            cnt_nxt       = '0;
            state_nxt     = SEND;
          end else begin
            acc_nxt = sum_in;
            cnt_nxt = cnt + CNT_ONE;
          end
        end else if (flush && (cnt != '0)) begin
          out_sum_nxt   = acc;
          out_count_nxt = cnt;
          out_valid_nxt = 1'b1;
          in_ready_nxt  = 1'b0;
          acc_nxt       = '0;
          cnt_nxt       = '0;
          state_nxt     = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
          state_nxt     = ACCUM;
        end
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      acc       <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      out_sum   <= out_sum_nxt;
      out_count <= out_count_nxt;
      out_valid <= out_valid_nxt;
      in_ready  <= in_ready_nxt;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: grouping, extremes, flush, back-pressure
// and reset recovery, with hand-computed expected sums.
module tb_product_accumulator;

  localparam int PROD_W  = 64;
  localparam int N_TERMS = 8;
  localparam int CNT_W   = $clog2(N_TERMS+1);
  localparam int ACC_W   = PROD_W + $clog2(N_TERMS);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_data;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]         out_count;

  int tests = 0;
  int fails = 0;

  product_accumulator #(.PROD_W(PROD_W), .N_TERMS(N_TERMS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then presents one product for one transfer.
  task automatic send(input logic signed [PROD_W-1:0] d, input logic fl);
    for (int i = 0; i < 50 && !in_ready; i++) step();
    in_valid = 1'b1;
    in_data  = d;
    flush    = fl;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Waits (bounded) for a result and consumes it; returns X on timeout.
  task automatic get_result(output logic signed [ACC_W-1:0] s, output logic [CNT_W-1:0] c);
    int i;
    for (i = 0; i < 50 && !out_valid; i++) step();
    if (out_valid) begin
      s = out_sum;
      c = out_count;
    end else begin
      s = 'x;
      c = 'x;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    tests++; if (out_sum !== '0) begin fails++; $display("FAIL reset_out_sum got %0d want 0", out_sum); end
    tests++; if (out_count !== '0) begin fails++; $display("FAIL reset_out_count got %0d want 0", out_count); end
    step();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_rise got %0b want 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    for (int k = 1; k <= 7; k++) send(PROD_W'(k), 1'b0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %0b want 0", out_valid); end
    send(64'sd8, 1'b0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %0b want 1", out_valid); end
    tests++; if (out_sum !== 67'sd36) begin fails++; $display("FAIL basic_sum got %0d want 36", out_sum); end
    tests++; if (out_count !== 4'd8) begin fails++; $display("FAIL basic_count got %0d want 8", out_count); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_ready_low got %0b want 0", in_ready); end
    step();
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_drop got %0b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_ready_back got %0b want 1", in_ready); end
    tests++; if (out_sum !== 67'sd36) begin fails++; $display("FAIL basic_sum_held got %0d want 36", out_sum); end
  endtask

  task automatic test_extremes();
    logic signed [ACC_W-1:0]  s;
    logic [CNT_W-1:0]         c;
    logic signed [PROD_W-1:0] mn;
    logic signed [ACC_W-1:0]  exp_mn;
    logic signed [PROD_W-1:0] mix [8];
    mn     = {1'b1, 63'd0};
    exp_mn = {1'b1, 66'd0};
    for (int k = 0; k < 8; k++) send(mn, 1'b0);
    get_result(s, c);
    tests++; if (s !== exp_mn) begin fails++; $display("FAIL min_sum got %0d want %0d", s, exp_mn); end
    tests++; if (c !== 4'd8) begin fails++; $display("FAIL min_count got %0d want 8", c); end
    mix = '{64'sd100, -64'sd100, 64'sd5, -64'sd5, 64'sh4000_0000_0000_0000,
            -64'sh4000_0000_0000_0000, 64'sd7, -64'sd7};
    for (int k = 0; k < 8; k++) send(mix[k], 1'b0);
    get_result(s, c);
    tests++; if (s !== 67'sd0) begin fails++; $display("FAIL mix_sum got %0d want 0", s); end
  endtask

  task automatic test_flush();
    logic signed [ACC_W-1:0] s;
    logic [CNT_W-1:0]        c;
    send(64'sd5, 1'b0); send(-64'sd7, 1'b0); send(64'sd10, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL flush_valid got %0b want 1", out_valid); end
    get_result(s, c);
    tests++; if (s !== 67'sd8) begin fails++; $display("FAIL flush_sum got %0d want 8", s); end
    tests++; if (c !== 4'd3) begin fails++; $display("FAIL flush_count got %0d want 3", c); end
    send(64'sd5, 1'b0); send(-64'sd7, 1'b0); send(64'sd10, 1'b0); send(64'sd4, 1'b1);
    get_result(s, c);
    tests++; if (s !== 67'sd12) begin fails++; $display("FAIL flushv_sum got %0d want 12", s); end
    tests++; if (c !== 4'd4) begin fails++; $display("FAIL flushv_count got %0d want 4", c); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    step(); step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_empty got %0b want 0", out_valid); end
    send(64'sd3, 1'b0); send(64'sd4, 1'b1);
    get_result(s, c);
    tests++; if (s !== 67'sd7) begin fails++; $display("FAIL flush_after_empty got %0d want 7", s); end
    tests++; if (c !== 4'd2) begin fails++; $display("FAIL flush_after_count got %0d want 2", c); end
  endtask

  task automatic test_back_pressure();
    logic signed [ACC_W-1:0] s;
    logic [CNT_W-1:0]        c;
    for (int k = 1; k <= 8; k++) send(PROD_W'(10 * k), 1'b0);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      flush    = ~k[0];
      in_data  = 64'sd999;
      step();
      tests++;
      if (out_valid !== 1'b1 || out_sum !== 67'sd360 || in_ready !== 1'b0)
        begin fails++; $display("FAIL hold_%0d got v=%0b sum=%0d rdy=%0b want v=1 sum=360 rdy=0", k, out_valid, out_sum, in_ready); end
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    get_result(s, c);
    tests++; if (s !== 67'sd360) begin fails++; $display("FAIL hold_sum got %0d want 360", s); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL hold_release got %0b want 0", out_valid); end
    for (int k = 1; k <= 8; k++) send(PROD_W'(k), 1'b0);
    get_result(s, c);
    tests++; if (s !== 67'sd36) begin fails++; $display("FAIL after_hold_sum got %0d want 36", s); end
  endtask

  task automatic test_reset_mid();
    logic signed [ACC_W-1:0] s;
    logic [CNT_W-1:0]        c;
    for (int k = 0; k < 4; k++) send(64'sd100, 1'b0);
    do_reset();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL midrst_ready got %0b want 0", in_ready); end
    for (int k = 1; k <= 8; k++) send(PROD_W'(k), 1'b0);
    get_result(s, c);
    tests++; if (s !== 67'sd36) begin fails++; $display("FAIL midrst_sum got %0d want 36", s); end
    for (int k = 0; k < 8; k++) send(64'sd50, 1'b0);
    step();
    do_reset();
    tests++; if (out_valid !== 1'b0 || out_sum !== '0)
      begin fails++; $display("FAIL sendrst got v=%0b sum=%0d want v=0 sum=0", out_valid, out_sum); end
    for (int k = 0; k < 8; k++) send(64'sd2, 1'b0);
    get_result(s, c);
    tests++; if (s !== 67'sd16) begin fails++; $display("FAIL sendrst_next got %0d want 16", s); end
    tests++; if (c !== 4'd8) begin fails++; $display("FAIL sendrst_count got %0d want 8", c); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_flush();
    test_back_pressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
